// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit.
package dmem_lsu_pkg;

   localparam int unsigned MEM_AW_DEF = 14;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_X = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      LD_CAP,
      RMW_CAP,
      WR,
      RESP
   } state_e;

endpackage

// File: rtl/dmem_lsu_if.sv
// Core-side request/response bundle and memory port-A bundle for dmem_lsu.
interface dmem_lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

interface dmem_mem_if
   import dmem_lsu_pkg::*;
#(
   parameter int unsigned MEM_AW = MEM_AW_DEF
);
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_din;
   logic              mem_we;
   logic [3:0]        mem_en;
   logic [31:0]       mem_dout;

   modport master (
      output mem_addr, mem_din, mem_we, mem_en,
      input  mem_dout
   );

   modport slave (
      input  mem_addr, mem_din, mem_we, mem_en,
      output mem_dout
   );
endinterface

// File: rtl/dmem_lsu_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
module lsu_align
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  size_e       size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data,
   output logic [31:0] st_data
);

   logic [4:0]  sh;
   logic [15:0] field;
   logic [31:0] mask;

   assign sh = {lane, 3'b000};

   // Half accesses are always even-aligned, so the byte shift also serves halves.
   always_comb begin
      field   = 16'(rdata >> sh);
      ld_data = rdata;
      mask    = '1;
      case (size)
         SZ_B: begin
            ld_data = {{24{~uns & field[7]}}, field[7:0]};
            mask    = 32'h0000_00FF << sh;
         end
         SZ_H: begin
            ld_data = {{16{~uns & field[15]}}, field[15:0]};
            mask    = 32'h0000_FFFF << sh;
         end
         default: ;
      endcase
      st_data = (rdata & ~mask) | ((wdata << sh) & mask);
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one transaction at a time, sub-word stores via read-modify-write.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int unsigned MEM_AW = MEM_AW_DEF
)
(
   input logic        clk,
   input logic        rst,
   dmem_lsu_if.slave  core,
   dmem_mem_if.master mem
);

   state_e            state, state_nx;
   size_e             req_size, size_q;
   logic              accept, req_err;
   logic              we_q, uns_q, err_q;
   logic [1:0]        lane_q;
   logic [MEM_AW-1:0] addr_q;
   logic [31:0]       wdata_q, rdata_q, din_q;
   logic [31:0]       ld_data, st_data;

   assign req_size       = size_e'(core.req_size);
   assign core.req_ready = (state == IDLE) && !rst;
   assign accept         = core.req_valid && core.req_ready;

   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_H:    req_err = core.req_addr[0];
         SZ_W:    req_err = (core.req_addr[1:0] != 2'b00);
         SZ_X:    req_err = 1'b1;
         default: ;
      endcase
      if ((core.req_addr >> (MEM_AW + 2)) != '0)
         req_err = 1'b1;
   end

   lsu_align u_align (
      .rdata   (mem.mem_dout),
      .lane    (lane_q),
      .size    (size_q),
      .uns     (uns_q),
      .wdata   (wdata_q),
      .ld_data (ld_data),
      .st_data (st_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      mem.mem_en  = 4'h0;
      mem.mem_we  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_err)                                state_nx = RESP;
               else if (core.req_we && (req_size == SZ_W)) state_nx = WR;
               else                                        state_nx = RD;
            end
         end
         RD: begin
            mem.mem_en = 4'hF;
            state_nx   = we_q ? RMW_CAP : LD_CAP;
         end
         LD_CAP:  state_nx = RESP;
         RMW_CAP: state_nx = WR;
         WR: begin
            mem.mem_en = 4'hF;
            mem.mem_we = 1'b1;
            state_nx   = RESP;
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= SZ_B;
         lane_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         din_q   <= '0;
      end else begin
         if (accept) begin
            we_q    <= core.req_we;
            uns_q   <= core.req_unsigned;
            err_q   <= req_err;
            size_q  <= req_size;
            lane_q  <= core.req_addr[1:0];
            addr_q  <= core.req_addr[MEM_AW+1:2];
            wdata_q <= core.req_wdata;
            rdata_q <= '0;
            if (core.req_we && (req_size == SZ_W) && !req_err)
               din_q <= core.req_wdata;
         end
         if (state == LD_CAP)  rdata_q <= ld_data;
         if (state == RMW_CAP) din_q   <= st_data;
      end
   end

   assign mem.mem_addr   = addr_q;
   assign mem.mem_din    = din_q;
   assign core.rsp_valid = (state == RESP);
   assign core.rsp_err   = (state == RESP) && err_q;
   assign core.rsp_rdata = (state == RESP) ? rdata_q : '0;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit sitting directly upstream of the dual-port data memory and driving its port A. It accepts one byte/half/word load or store per transaction from the core, translates the byte address into a 14-bit word address, and issues whole-word memory accesses. Because a memory write replaces the entire word (disabled lanes are written as zero), sub-word stores are done as read-modify-write. Loads are lane-extracted and sign- or zero-extended before being returned.

## Interface
Parameters:
- MEM_AW, 14, memory word-address width; byte addresses at or above 2^(MEM_AW+2) are out of range.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a cycle where req_valid and req_ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle completion pulse; the consumer cannot back-pressure it.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned, illegal size, or out of range.
- mem_addr  out  MEM_AW  word address, equal to req_addr[MEM_AW+1:2].
- mem_din  out  32  write word.
- mem_we  out  1  write strobe.
- mem_en  out  4  lane enables; 4'hF during any access, 4'h0 otherwise.
- mem_dout  in  32  read word, valid one cycle after a read is issued.

## Operation
- Request fields are registered on acceptance.
- Error checks:
  - req_size = 11 is an error.
  - Half access with addr[0] = 1 is an error.
  - Word access with addr[1:0] != 0 is an error.
  - addr[31:MEM_AW+2] != 0 is an error.
  - An erroring request makes no memory access.
- FSM states: IDLE, RD, LD_CAP, RMW_CAP, WR, RESP.
  - IDLE goes to RESP on an error.
  - IDLE goes to WR on a word store.
  - IDLE goes to RD on a load or a sub-word store.
  - RD goes to LD_CAP for a load, or to RMW_CAP for a store.
  - LD_CAP goes to RESP.
  - RMW_CAP goes to WR.
  - WR goes to RESP.
  - RESP goes to IDLE.
- Memory-port drive by state:
  - RD: mem_en = F, mem_we = 0.
  - WR: mem_en = F, mem_we = 1.
  - All other states: mem_en = 0, mem_we = 0, mem_din held.
- Loads (little-endian): lane = addr[1:0] for bytes, addr[1] for halves. The selected field is shifted to bit 0, then sign- or zero-extended. Word loads return the word unchanged.
- Sub-word stores: the low byte or half of req_wdata replaces only the addressed lane of the word captured in RMW_CAP. All other lanes are preserved.
- Word stores: mem_din = req_wdata.

## Timing
Cycle 0 is the acceptance cycle.
- Error: rsp_valid = 1, rsp_err = 1 in cycle 1.
- Word store: write issued in cycle 1; rsp_valid in cycle 2.
- Load: read issued in cycle 1; mem_dout captured at the end of cycle 2; rsp_valid with rsp_rdata in cycle 3.
- Sub-word store: read in cycle 1, merge captured in cycle 2, write in cycle 3, rsp_valid in cycle 4.
- Throughput: the next request can be accepted no earlier than the cycle after RESP.
- Reset values: state IDLE; req_ready 0 while rst is high and 1 after release; all other outputs 0.
- Reset asserted mid-transaction: mem_en and mem_we drop immediately (asynchronously) and the transaction is abandoned. A read-modify-write interrupted before WR leaves memory untouched.
- No simultaneous-request hazard exists, because the block handles only one transaction at a time.

## Structure
- Package dmem_lsu_pkg holds:
  - the size encodings SZ_B, SZ_H, SZ_W;
  - the FSM state enum;
  - the default MEM_AW.
- One combinational sub-module, lsu_align, provides extract-and-extend for loads and lane merge for stores. The top level holds the FSM and request registers.

## Test plan
Memory initial image: word 5 = 0x11223344, word 8 = 0x80001234.
- Unsigned byte load at 0x15 -> rsp_valid in cycle 3; rdata = 0x00000033; mem_addr = 5.
- Signed half load at 0x22 -> rdata = 0xFFFF8000; the same load unsigned -> 0x00008000.
- Byte store of 0xAB at 0x17 -> read in cycle 1; write in cycle 3 with mem_din = 0xAB223344; rsp in cycle 4. A following word load of 0x14 returns 0xAB223344.
- Each of these requests -> rsp_err = 1 in cycle 1 and mem_en never asserted:
  - word store at 0x12;
  - half load at 0x03;
  - any access at 0x00010000;
  - req_size = 11.
- rst pulsed in cycle 2 of a byte store to 0x14 -> mem_en = 0 immediately; word 5 is unchanged; req_ready returns to 1 after release.
- req_valid held high across two back-to-back word stores -> req_ready is 0 while busy; the second store is accepted only after the first rsp_valid, and both words are written correctly.
